// File: rtl/game2048_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game2048_pkg
// Description : Shared types, constants and the line-to-cell index map for
//               the 2048 board engine.
// Revision    : 1.0 - initial release
// ============================================================================
package game2048_pkg;

    localparam int          TILE_W    = 4;
    localparam logic [1:0]  DIR_UP    = 2'd0;
    localparam logic [1:0]  DIR_DOWN  = 2'd1;
    localparam logic [1:0]  DIR_LEFT  = 2'd2;
    localparam logic [1:0]  DIR_RIGHT = 2'd3;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [3:0] {
        ST_INIT0  = 4'd0,
        ST_INIT1  = 4'd1,
        ST_IDLE   = 4'd2,
        ST_LINE0  = 4'd3,
        ST_LINE1  = 4'd4,
        ST_LINE2  = 4'd5,
        ST_LINE3  = 4'd6,
        ST_SPAWN  = 4'd7,
        ST_COMMIT = 4'd8
    } state_t;

    // Cell index of element j of line k, j=0 being nearest the slide target.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir,
                                            input logic [1:0] k,
                                            input logic [1:0] j);
        logic [3:0] k4;
        logic [3:0] j4;
        k4 = {2'b00, k};
        j4 = {2'b00, j};
        case (dir)
            DIR_LEFT:  cell_idx = 4'd15 - {k, 2'b00} - j4;
            DIR_RIGHT: cell_idx = 4'd12 - {k, 2'b00} + j4;
            DIR_UP:    cell_idx = 4'd15 - k4 - {j, 2'b00};
            default:   cell_idx = 4'd3  - k4 + {j, 2'b00};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_merge4.sv
`default_nettype none
// ============================================================================
// Module      : line_merge4
// Description : Combinational compress-and-merge of one 4-cell line.
// Revision    : 1.0 - initial release
// ============================================================================
module line_merge4 (
    input  logic [3:0][3:0] i_line,
    output logic [3:0][3:0] o_line,
    output logic            o_changed,
    output logic [15:0]     o_points
);

    logic [3:0][3:0] w_comp;
    logic [4:0][3:0] w_ext;
    logic [1:0]      w_cnt;
    logic [1:0]      w_wr;
    logic            w_skip;
    logic [16:0]     w_pts;

    always_comb begin
        w_comp = '0;
        w_cnt  = '0;
        for (int j = 0; j < 4; j++) begin
            if (i_line[j] != 4'd0) begin
                w_comp[w_cnt] = i_line[j];
                w_cnt         = w_cnt + 2'd1;
            end
        end
    end

    // Zero pad lets element 3 look at a neighbour that never matches.
    assign w_ext = {4'h0, w_comp};

    always_comb begin
        o_line = '0;
        w_wr   = '0;
        w_skip = 1'b0;
        w_pts  = '0;
        for (int j = 0; j < 4; j++) begin
            if (w_skip) begin
                w_skip = 1'b0;
            end else if (w_ext[j] != 4'd0) begin
                if (w_ext[j] == w_ext[j+1] && w_ext[j] != 4'hF) begin
                    o_line[w_wr] = w_ext[j] + 4'd1;
                    w_pts        = w_pts + (17'd1 << (w_ext[j] + 4'd1));
                    w_skip       = 1'b1;
                end else begin
                    o_line[w_wr] = w_ext[j];
                end
                w_wr = w_wr + 2'd1;
            end
        end
    end

    assign o_changed = (o_line != i_line);
    assign o_points  = w_pts[16] ? 16'hFFFF : w_pts[15:0];

endmodule
`default_nettype wire

// File: rtl/board_logic_engine.sv
`default_nettype none
// ============================================================================
// Module      : board_logic_engine
// Description : 2048 game-state engine: moves, spawns, score, win/game-over.
// Revision    : 1.0 - initial release
// ============================================================================
module board_logic_engine
    import game2048_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  WIN_EXP   = 4'd11
) (
    input  logic        clk_65,
    input  logic        rst,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    input  logic        new_game,
    input  logic        load_en,
    input  logic [63:0] load_board,
    output logic        move_ready,
    output logic [63:0] current_state,
    output logic [15:0] score,
    output logic        win,
    output logic        game_over
);

    state_t          r_state;
    state_t          w_state_next;
    logic [63:0]     r_shadow;
    logic [15:0]     r_lfsr;
    logic [1:0]      r_dir;
    logic [17:0]     r_acc;
    logic            r_changed;
    logic [3:0]      r_probe;
    logic [3:0]      r_cnt;
    logic [3:0]      r_sval;

    logic [1:0]      w_k;
    logic [3:0][3:0] w_line_in;
    logic [3:0][3:0] w_line_out;
    logic            w_line_changed;
    logic [15:0]     w_points;
    logic [63:0]     w_merged_board;
    logic            w_spawn_empty;
    logic            w_spawn_done;
    logic            w_enter_spawn;
    logic [18:0]     w_sum;
    logic            w_win;
    logic            w_over;
    logic [63:0]     w_sh_h;
    logic [63:0]     w_sh_v;

    always_comb begin
        case (r_state)
            ST_LINE1: w_k = 2'd1;
            ST_LINE2: w_k = 2'd2;
            ST_LINE3: w_k = 2'd3;
            default:  w_k = 2'd0;
        endcase
    end

    always_comb begin
        w_line_in = '0;
        for (int j = 0; j < 4; j++) begin
            w_line_in[j] = r_shadow[{cell_idx(r_dir, w_k, j[1:0]), 2'b00} +: 4];
        end
    end

    line_merge4 u_merge (
        .i_line    (w_line_in),
        .o_line    (w_line_out),
        .o_changed (w_line_changed),
        .o_points  (w_points)
    );

    always_comb begin
        w_merged_board = r_shadow;
        for (int j = 0; j < 4; j++) begin
            w_merged_board[{cell_idx(r_dir, w_k, j[1:0]), 2'b00} +: 4] = w_line_out[j];
        end
    end

    assign w_spawn_empty = (r_shadow[{r_probe, 2'b00} +: 4] == 4'd0);
    assign w_spawn_done  = w_spawn_empty || (r_cnt == 4'd15);
    assign w_sum         = {3'b000, score} + {1'b0, r_acc};

    // Neighbour views: cell i+1 and cell i+4 aligned onto cell i.
    assign w_sh_h = {4'h0, r_shadow[63:4]};
    assign w_sh_v = {16'h0, r_shadow[63:16]};

    always_comb begin
        w_win  = 1'b0;
        w_over = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (r_shadow[4*i +: 4] >= WIN_EXP)                      w_win  = 1'b1;
            if (r_shadow[4*i +: 4] == 4'd0)                         w_over = 1'b0;
            if ((i % 4) != 3 && r_shadow[4*i +: 4] == w_sh_h[4*i +: 4]) w_over = 1'b0;
            if (i < 12 && r_shadow[4*i +: 4] == w_sh_v[4*i +: 4])       w_over = 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT0:  if (w_spawn_done) w_state_next = ST_INIT1;
            ST_INIT1:  if (w_spawn_done) w_state_next = ST_COMMIT;
            ST_IDLE: begin
                if (load_en)         w_state_next = ST_COMMIT;
                else if (new_game)   w_state_next = ST_INIT0;
                else if (move_valid) w_state_next = ST_LINE0;
            end
            ST_LINE0:  w_state_next = ST_LINE1;
            ST_LINE1:  w_state_next = ST_LINE2;
            ST_LINE2:  w_state_next = ST_LINE3;
            ST_LINE3:  w_state_next = (r_changed || w_line_changed) ? ST_SPAWN : ST_COMMIT;
            ST_SPAWN:  if (w_spawn_done) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_INIT0;
        endcase
    end

    assign move_ready    = (r_state == ST_IDLE);
    assign w_enter_spawn = (w_state_next != r_state) &&
                           (w_state_next == ST_INIT0 || w_state_next == ST_INIT1 ||
                            w_state_next == ST_SPAWN);

    always_ff @(posedge clk_65 or negedge rst) begin
        if (!rst) r_state <= ST_INIT0;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk_65 or negedge rst) begin
        if (!rst) begin
            r_lfsr        <= LFSR_SEED;
            r_shadow      <= '0;
            r_dir         <= '0;
            r_acc         <= '0;
            r_changed     <= 1'b0;
            r_probe       <= LFSR_SEED[3:0];
            r_cnt         <= '0;
            r_sval        <= (LFSR_SEED[7:4] == 4'd0) ? 4'd2 : 4'd1;
            current_state <= '0;
            score         <= '0;
            win           <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_POLY)};
            case (r_state)
                ST_INIT0, ST_INIT1, ST_SPAWN: begin
                    if (w_spawn_empty) begin
                        r_shadow[{r_probe, 2'b00} +: 4] <= r_sval;
                    end else begin
                        r_probe <= r_probe + 4'd1;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (load_en) begin
                        r_shadow <= load_board;
                        r_acc    <= '0;
                        score    <= '0;
                        win      <= 1'b0;
                    end else if (new_game) begin
                        r_shadow <= '0;
                        r_acc    <= '0;
                        score    <= '0;
                        win      <= 1'b0;
                    end else if (move_valid) begin
                        r_dir     <= move_dir;
                        r_acc     <= '0;
                        r_changed <= 1'b0;
                    end
                end
                ST_LINE0, ST_LINE1, ST_LINE2, ST_LINE3: begin
                    r_shadow  <= w_merged_board;
                    r_acc     <= r_acc + {2'b00, w_points};
                    r_changed <= r_changed | w_line_changed;
                end
                ST_COMMIT: begin
                    current_state <= r_shadow;
                    score         <= (|w_sum[18:16]) ? 16'hFFFF : w_sum[15:0];
                    win           <= win | w_win;
                    game_over     <= w_over;
                end
                default: ;
            endcase
            // Probe start and tile value come from the LFSR as a spawn state is entered.
            if (w_enter_spawn) begin
                r_probe <= r_lfsr[3:0];
                r_sval  <= (r_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
                r_cnt   <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_logic_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_logic_engine
// Description : Directed self-checking bench for board_logic_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_logic_engine;

    logic        clk_65     = 1'b0;
    logic        rst        = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  move_dir   = 2'd0;
    logic        new_game   = 1'b0;
    logic        load_en    = 1'b0;
    logic [63:0] load_board = '0;
    logic        move_ready;
    logic [63:0] current_state;
    logic [15:0] score;
    logic        win;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk_65 = ~clk_65;

    board_logic_engine #(.LFSR_SEED(16'hACE1), .WIN_EXP(4'd11)) dut (
        .clk_65        (clk_65),
        .rst           (rst),
        .move_valid    (move_valid),
        .move_dir      (move_dir),
        .new_game      (new_game),
        .load_en       (load_en),
        .load_board    (load_board),
        .move_ready    (move_ready),
        .current_state (current_state),
        .score         (score),
        .win           (win),
        .game_over     (game_over)
    );

    function automatic int count_nz(input logic [63:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (b[4*i +: 4] != 4'd0) n++;
        return n;
    endfunction

    function automatic bit all_small(input logic [63:0] b);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++)
            if (b[4*i +: 4] > 4'd2) ok = 1'b0;
        return ok;
    endfunction

    // True when b equals base except for one cell, empty in base, holding 1 or 2.
    function automatic bit spawn_ok(input logic [63:0] b, input logic [63:0] base);
        int         diffs;
        bit         ok;
        logic [3:0] bv;
        logic [3:0] ev;
        diffs = 0;
        ok    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bv = b[4*i +: 4];
            ev = base[4*i +: 4];
            if (bv !== ev) begin
                diffs++;
                if (ev != 4'd0 || !(bv == 4'd1 || bv == 4'd2)) ok = 1'b0;
            end
        end
        return ok && (diffs == 1);
    endfunction

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (move_ready !== 1'b1 && n < limit) begin
            @(negedge clk_65);
            n++;
        end
    endtask

    task automatic do_load(input logic [63:0] b);
        int n;
        wait_ready(40, n);
        load_en    = 1'b1;
        load_board = b;
        @(negedge clk_65);
        load_en    = 1'b0;
        wait_ready(5, n);
    endtask

    task automatic do_move(input logic [1:0] dir, output bit dropped, output int n);
        int w;
        wait_ready(40, w);
        move_valid = 1'b1;
        move_dir   = dir;
        @(negedge clk_65);
        move_valid = 1'b0;
        dropped    = (move_ready === 1'b0);
        wait_ready(40, n);
    endtask

    task automatic test_reset;
        int n;
        repeat (3) @(negedge clk_65);
        checks++;
        if (current_state !== 64'h0 || move_ready !== 1'b0 || score !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: state=%h ready=%b score=%h, need 0/0/0", current_state, move_ready, score);
        end
        rst = 1'b1;
        wait_ready(40, n);
        checks++;
        if (move_ready !== 1'b1 || n > 33) begin
            errors++;
            $display("FAIL reset_ready: ready=%b after %0d cycles, need 1 within 33", move_ready, n);
        end
        checks++;
        if (count_nz(current_state) != 2 || !all_small(current_state)) begin
            errors++;
            $display("FAIL reset_tiles: board=%h, need two tiles of value 1 or 2", current_state);
        end
        checks++;
        if (score !== 16'h0 || win !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: score=%h win=%b over=%b, need 0/0/0", score, win, game_over);
        end
    endtask

    task automatic test_row_merge;
        bit dropped;
        int n;
        do_load(64'h1111_0000_0000_0000);
        checks++;
        if (current_state !== 64'h1111_0000_0000_0000 || score !== 16'h0) begin
            errors++;
            $display("FAIL load_row: state=%h score=%h, need 1111000000000000/0", current_state, score);
        end
        do_move(2'd2, dropped, n);
        checks++;
        if (!dropped) begin
            errors++;
            $display("FAIL ready_drop: ready still 1 after accept, need 0");
        end
        checks++;
        if (current_state[63:56] !== 8'h22 || !spawn_ok(current_state, 64'h2200_0000_0000_0000)) begin
            errors++;
            $display("FAIL row_merge: state=%h, need 22.. plus one new tile", current_state);
        end
        checks++;
        if (score !== 16'd8) begin
            errors++;
            $display("FAIL row_score: score=%0d, need 8", score);
        end
    endtask

    task automatic test_priority;
        int n;
        wait_ready(40, n);
        load_en    = 1'b1;
        new_game   = 1'b1;
        load_board = 64'h0000_0000_0021_0000;
        @(negedge clk_65);
        load_en  = 1'b0;
        new_game = 1'b0;
        wait_ready(3, n);
        checks++;
        if (n != 1 || current_state !== 64'h0000_0000_0021_0000 || score !== 16'h0) begin
            errors++;
            $display("FAIL load_priority: cycles=%0d state=%h score=%0d, need 1/0000000000210000/0", n, current_state, score);
        end
        new_game = 1'b1;
        @(negedge clk_65);
        new_game = 1'b0;
        checks++;
        if (move_ready !== 1'b0 || current_state !== 64'h0000_0000_0021_0000) begin
            errors++;
            $display("FAIL newgame_atomic: ready=%b state=%h, need 0 and old board", move_ready, current_state);
        end
        wait_ready(40, n);
        checks++;
        if (n > 33 || count_nz(current_state) != 2 || !all_small(current_state) || score !== 16'h0) begin
            errors++;
            $display("FAIL new_game: cycles=%0d state=%h score=%0d, need <=33, two small tiles, 0", n, current_state, score);
        end
    endtask

    task automatic test_noop;
        bit dropped;
        int n;
        do_load(64'h1000_0000_0000_0000);
        do_move(2'd2, dropped, n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL noop_latency: ready after %0d cycles, need 5", n);
        end
        checks++;
        if (current_state !== 64'h1000_0000_0000_0000 || score !== 16'h0) begin
            errors++;
            $display("FAIL noop_board: state=%h score=%0d, need 1000000000000000/0", current_state, score);
        end
    endtask

    task automatic test_column;
        bit dropped;
        int n;
        do_load(64'h0000_0000_0000_0001);
        do_move(2'd0, dropped, n);
        checks++;
        if (current_state[51:48] !== 4'd1 || !spawn_ok(current_state, 64'h0001_0000_0000_0000)) begin
            errors++;
            $display("FAIL column_slide: state=%h, need cell12=1 plus one new tile", current_state);
        end
        checks++;
        if (score !== 16'h0 || n < 6 || n > 21) begin
            errors++;
            $display("FAIL column_misc: score=%0d latency=%0d, need 0 and 6..21", score, n);
        end
    endtask

    task automatic test_win;
        bit dropped;
        int n;
        do_load(64'hAA00_0000_0000_0000);
        checks++;
        if (win !== 1'b0) begin
            errors++;
            $display("FAIL win_early: win=%b, need 0", win);
        end
        do_move(2'd2, dropped, n);
        checks++;
        if (current_state[63:60] !== 4'hB || win !== 1'b1 ||
            !spawn_ok(current_state, 64'hB000_0000_0000_0000)) begin
            errors++;
            $display("FAIL win_merge: state=%h win=%b, need B..., win 1", current_state, win);
        end
        checks++;
        if (score !== 16'd2048) begin
            errors++;
            $display("FAIL win_score: score=%0d, need 2048", score);
        end
    endtask

    task automatic test_gameover;
        bit dropped;
        int n;
        wait_ready(40, n);
        load_en    = 1'b1;
        load_board = 64'h1212_2121_1212_2121;
        @(negedge clk_65);
        load_en = 1'b0;
        checks++;
        if (game_over !== 1'b0) begin
            errors++;
            $display("FAIL over_early: game_over=%b before COMMIT, need 0", game_over);
        end
        @(negedge clk_65);
        checks++;
        if (game_over !== 1'b1 || move_ready !== 1'b1 || current_state !== 64'h1212_2121_1212_2121) begin
            errors++;
            $display("FAIL over_set: over=%b ready=%b state=%h, need 1/1/loaded", game_over, move_ready, current_state);
        end
        do_move(2'd3, dropped, n);
        checks++;
        if (n != 5 || game_over !== 1'b1 || current_state !== 64'h1212_2121_1212_2121 || score !== 16'h0) begin
            errors++;
            $display("FAIL over_move: lat=%0d over=%b state=%h score=%0d, need 5/1/unchanged/0", n, game_over, current_state, score);
        end
    endtask

    task automatic test_abort;
        bit dropped;
        int n;
        do_load(64'hAA00_0000_0000_0000);
        do_move(2'd2, dropped, n);
        wait_ready(40, n);
        move_valid = 1'b1;
        move_dir   = 2'd3;
        @(negedge clk_65);
        move_valid = 1'b0;
        repeat (2) @(negedge clk_65);
        rst = 1'b0;
        #1;
        checks++;
        if (current_state !== 64'h0 || score !== 16'h0 || win !== 1'b0 ||
            game_over !== 1'b0 || move_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: state=%h score=%0d win=%b over=%b ready=%b, need all 0",
                     current_state, score, win, game_over, move_ready);
        end
        @(negedge clk_65);
        rst = 1'b1;
        wait_ready(40, n);
        checks++;
        if (n > 33 || count_nz(current_state) != 2 || !all_small(current_state) || score !== 16'h0) begin
            errors++;
            $display("FAIL abort_init: cycles=%0d state=%h score=%0d, need <=33, two small tiles, 0", n, current_state, score);
        end
    endtask

    initial begin
        test_reset();
        test_row_merge();
        test_priority();
        test_noop();
        test_column();
        test_win();
        test_gameover();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
